// File: rtl/bus_memtest_pkg.sv
// rtl/bus_memtest_pkg.sv - shared constants for the bus memory self-test master
package bus_memtest_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WR_REQ  = 3'd1;
   localparam logic [2:0] ST_RD_REQ  = 3'd2;
   localparam logic [2:0] ST_RD_WAIT = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   localparam logic [3:0] BE_FULL     = 4'hF;
   localparam int         WORD_STRIDE = 4;

endpackage

// File: rtl/bus_memtest_pattern.sv
// rtl/bus_memtest_pattern.sv - address-derived test word, shared by write and compare paths
module bus_memtest_pattern #(
   parameter logic [31:0] SEED = 32'hA5A5_0000
) (
   input  logic [31:0] addr_i,
   input  logic        inv_i,
   output logic [31:0] word_o
);

   assign word_o = addr_i ^ SEED ^ {32{inv_i}};

endmodule

// File: rtl/bus_memtest_master.sv
// rtl/bus_memtest_master.sv - bus initiator that writes a pattern to N words, reads back and compares
module bus_memtest_master
   import bus_memtest_pkg::*;
#(
   parameter logic [31:0] SEED         = 32'hA5A5_0000,
   parameter int          RESP_TIMEOUT = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] base_addr_i,
   input  logic [15:0] num_words_i,
   input  logic        inv_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] err_cnt_o,
   output logic [31:0] first_err_addr_o,
   output logic        timeout_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_bo,
   output logic [3:0]  bus_be_bo,
   output logic [31:0] bus_wdata_bo,
   input  logic        bus_ack_i,
   input  logic        bus_resp_i,
   input  logic [31:0] bus_rdata_bi
);

   localparam int             TW        = $clog2(RESP_TIMEOUT + 1);
   localparam logic [TW-1:0]  TIMER_MAX = TW'(RESP_TIMEOUT);

   logic [2:0]    state_q, state_d;
   logic [15:0]   idx_q, idx_d;
   logic [15:0]   num_q, num_d;
   logic [31:0]   base_q, base_d;
   logic          inv_q, inv_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [15:0]   err_cnt_q, err_cnt_d;
   logic [31:0]   first_err_q, first_err_d;
   logic          timeout_q, timeout_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          req_q, req_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    be_q, be_d;

   logic          last_word;
   logic          nxt_inv;
   logic [15:0]   nxt_idx;
   logic [31:0]   nxt_base;
   logic [31:0]   nxt_addr;
   logic [31:0]   nxt_wdata;
   logic [31:0]   exp_rdata;

   // Next-request address is computed outside the FSM so the pattern generator sits off the state loop.
   assign last_word = (idx_q == num_q - 16'd1);
   assign nxt_base  = (state_q == ST_IDLE) ? (base_addr_i & ~32'h3) : base_q;
   assign nxt_inv   = (state_q == ST_IDLE) ? inv_i : inv_q;
   assign nxt_idx   = ((state_q == ST_IDLE) || last_word) ? 16'd0 : idx_q + 16'd1;
   assign nxt_addr  = nxt_base + 32'(nxt_idx) * 32'(WORD_STRIDE);

   bus_memtest_pattern #(.SEED(SEED)) u_wr_pattern (
      .addr_i (nxt_addr),
      .inv_i  (nxt_inv),
      .word_o (nxt_wdata)
   );

   bus_memtest_pattern #(.SEED(SEED)) u_cmp_pattern (
      .addr_i (addr_q),
      .inv_i  (inv_q),
      .word_o (exp_rdata)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      num_d       = num_q;
      base_d      = base_q;
      inv_d       = inv_q;
      timer_d     = timer_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      timeout_d   = timeout_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               base_d      = nxt_base;
               num_d       = num_words_i;
               inv_d       = inv_i;
               idx_d       = 16'd0;
               err_cnt_d   = 16'd0;
               first_err_d = 32'd0;
               timeout_d   = 1'b0;
               busy_d      = 1'b1;
               if (num_words_i == 16'd0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_WR_REQ;
                  req_d   = 1'b1;
                  we_d    = 1'b1;
                  addr_d  = nxt_addr;
                  wdata_d = nxt_wdata;
                  be_d    = BE_FULL;
               end
            end
         end
         ST_WR_REQ: begin
            if (bus_ack_i) begin
               idx_d  = nxt_idx;
               addr_d = nxt_addr;
               if (last_word) begin
                  state_d = ST_RD_REQ;
                  we_d    = 1'b0;
                  wdata_d = 32'd0;
               end else begin
                  wdata_d = nxt_wdata;
               end
            end
         end
         ST_RD_REQ: begin
            if (bus_ack_i) begin
               req_d   = 1'b0;
               timer_d = '0;
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            // A response arriving on the expiry cycle still counts; it is checked before the timer.
            if (bus_resp_i) begin
               if (bus_rdata_bi != exp_rdata) begin
                  if (err_cnt_q == 16'd0) first_err_d = addr_q;
                  if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
               end
               if (last_word) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RD_REQ;
                  idx_d   = nxt_idx;
                  req_d   = 1'b1;
                  addr_d  = nxt_addr;
               end
            end else if (timer_q == TIMER_MAX) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         idx_q       <= 16'd0;
         num_q       <= 16'd0;
         base_q      <= 32'd0;
         inv_q       <= 1'b0;
         timer_q     <= '0;
         err_cnt_q   <= 16'd0;
         first_err_q <= 32'd0;
         timeout_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         be_q        <= 4'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         num_q       <= num_d;
         base_q      <= base_d;
         inv_q       <= inv_d;
         timer_q     <= timer_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         timeout_q   <= timeout_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
      end
   end

   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign err_cnt_o        = err_cnt_q;
   assign first_err_addr_o = first_err_q;
   assign timeout_o        = timeout_q;
   assign bus_req_o        = req_q;
   assign bus_we_o         = we_q;
   assign bus_addr_bo      = addr_q;
   assign bus_be_bo        = be_q;
   assign bus_wdata_bo     = wdata_q;

endmodule

// File: tb/tb_bus_memtest_master.sv
// tb/tb_bus_memtest_master.sv - randomized self-checking bench with a RAM responder and traffic model
module tb_bus_memtest_master;

   localparam logic [31:0] SEED = 32'hA5A5_0000;
   localparam int          TO   = 1024;

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic        start  = 1'b0;
   logic [31:0] base   = 32'd0;
   logic [15:0] nwords = 16'd0;
   logic        inv    = 1'b0;
   logic        busy, done, timeout, req, we;
   logic [15:0] err_cnt;
   logic [31:0] first_err, addr, wdata;
   logic [3:0]  be;
   logic        ack   = 1'b0;
   logic        resp  = 1'b0;
   logic [31:0] rdata = 32'd0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int          stall_cfg    = 0;
   int          resp_lat     = 0;
   bit          never_resp   = 1'b0;
   bit          corrupt_en   = 1'b0;
   bit          spurious     = 1'b0;
   logic [31:0] corrupt_addr = 32'd0;

   logic [31:0] mem [logic [31:0]];
   logic [64:0] obs_q [$];
   logic [64:0] exp_q [$];
   int          unstable    = 0;
   int          be_bad      = 0;
   int          last_rd_cyc = 0;
   int          stall_cnt   = 0;
   int          pend_cnt    = 0;
   bit          pend        = 1'b0;
   bit          hold_valid  = 1'b0;
   logic [64:0] hold_txn    = '0;
   logic [31:0] pend_data   = 32'd0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   bus_memtest_master #(.SEED(SEED), .RESP_TIMEOUT(TO)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .start_i          (start),
      .base_addr_i      (base),
      .num_words_i      (nwords),
      .inv_i            (inv),
      .busy_o           (busy),
      .done_o           (done),
      .err_cnt_o        (err_cnt),
      .first_err_addr_o (first_err),
      .timeout_o        (timeout),
      .bus_req_o        (req),
      .bus_we_o         (we),
      .bus_addr_bo      (addr),
      .bus_be_bo        (be),
      .bus_wdata_bo     (wdata),
      .bus_ack_i        (ack),
      .bus_resp_i       (resp),
      .bus_rdata_bi     (rdata)
   );

   // Slave model: RAM with configurable ack stall, response latency, bit corruption and silence.
   always @(negedge clk) begin
      logic [64:0] t;
      logic [31:0] rd;
      ack  = 1'b0;
      resp = 1'b0;
      if (rst) begin
         pend       = 1'b0;
         stall_cnt  = 0;
         hold_valid = 1'b0;
      end else begin
         if (spurious) begin
            resp  = 1'b1;
            rdata = 32'h1234_5678;
         end
         if (pend) begin
            if (pend_cnt == 0) begin
               if (!never_resp) begin
                  resp  = 1'b1;
                  rdata = pend_data;
               end
               pend = 1'b0;
            end else begin
               pend_cnt--;
            end
         end
         if (req) begin
            t = {we, addr, (we ? wdata : 32'h0)};
            if (hold_valid && (t !== hold_txn)) unstable++;
            if (be !== 4'hF) be_bad++;
            if (stall_cnt >= stall_cfg) begin
               ack        = 1'b1;
               stall_cnt  = 0;
               hold_valid = 1'b0;
               obs_q.push_back(t);
               if (we) begin
                  mem[addr] = wdata;
               end else begin
                  rd = mem.exists(addr) ? mem[addr] : 32'h0;
                  if (corrupt_en && addr == corrupt_addr) rd = rd ^ 32'h1;
                  pend        = 1'b1;
                  pend_cnt    = resp_lat;
                  pend_data   = rd;
                  last_rd_cyc = cyc;
               end
            end else begin
               stall_cnt++;
               hold_valid = 1'b1;
               hold_txn   = t;
            end
         end
      end
   end

   // Reference traffic: N pattern writes at base+4i (mod 2^32), then N reads of the same addresses.
   task automatic build_expected(input logic [31:0] b, input int n, input logic iv);
      logic [31:0] a;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         a = b + 32'(i) * 32'd4;
         exp_q.push_back({1'b1, a, a ^ SEED ^ (iv ? 32'hFFFF_FFFF : 32'h0)});
      end
      for (int i = 0; i < n; i++) begin
         a = b + 32'(i) * 32'd4;
         exp_q.push_back({1'b0, a, 32'h0});
      end
   endtask

   task automatic run_transfer(input logic [31:0] b, input logic [15:0] n, input logic iv,
                               input int restart_at, output int cycles, output bit finished);
      @(negedge clk);
      base   = b;
      nwords = n;
      inv    = iv;
      start  = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      cycles   = 0;
      finished = 1'b0;
      while (!finished && cycles < 4000) begin
         if (done) begin
            finished = 1'b1;
         end else begin
            if (cycles == restart_at) begin
               base   = 32'h0000_5000;
               nwords = 16'd9;
               inv    = ~iv;
               start  = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            cycles++;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, err_cnt, first_err, timeout, req, we, addr, be, wdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b done=%b err=%h ferr=%h to=%b req=%b addr=%h be=%h want all 0",
                  busy, done, err_cnt, first_err, timeout, req, addr, be);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ideal();
      int cycles, ob, bb;
      bit fin;
      stall_cfg = 0; resp_lat = 0;
      ob = obs_q.size(); bb = be_bad;
      build_expected(32'h100, 4, 1'b0);
      run_transfer(32'h100, 16'd4, 1'b0, -1, cycles, fin);
      checks++;
      if (!fin) begin errors++; $display("FAIL ideal_done got no done want done pulse"); end
      checks++;
      if (obs_q.size() - ob !== exp_q.size()) begin
         errors++; $display("FAIL ideal_count got %0d want %0d", obs_q.size() - ob, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[ob+i] !== exp_q[i]) begin
            errors++; $display("FAIL ideal_txn%0d got %h want %h", i, obs_q[ob+i], exp_q[i]);
         end
      end
      checks++;
      if ({err_cnt, first_err, timeout, busy} !== '0) begin
         errors++; $display("FAIL ideal_result got err=%0d ferr=%h to=%b busy=%b want 0 0 0 0", err_cnt, first_err, timeout, busy);
      end
      checks++;
      if (be_bad !== bb) begin errors++; $display("FAIL ideal_be got %0d bad want 0", be_bad - bb); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL ideal_done_width got %b want 0", done); end
   endtask

   task automatic test_stall();
      int cycles, ob, ub;
      bit fin;
      stall_cfg = 3; resp_lat = 0;
      ob = obs_q.size(); ub = unstable;
      build_expected(32'h300, 5, 1'b1);
      run_transfer(32'h300, 16'd5, 1'b1, -1, cycles, fin);
      checks++;
      if (obs_q.size() - ob !== 10) begin errors++; $display("FAIL stall_count got %0d want 10", obs_q.size() - ob); end
      for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[ob+i] !== exp_q[i]) begin
            errors++; $display("FAIL stall_txn%0d got %h want %h", i, obs_q[ob+i], exp_q[i]);
         end
      end
      checks++;
      if (unstable !== ub) begin errors++; $display("FAIL stall_stable got %0d changes want 0", unstable - ub); end
      checks++;
      if (!fin || err_cnt !== 16'd0) begin errors++; $display("FAIL stall_result got fin=%b err=%0d want 1 0", fin, err_cnt); end
      stall_cfg = 0;
   endtask

   task automatic test_corrupt();
      int cycles;
      bit fin;
      corrupt_en = 1'b1; corrupt_addr = 32'h108;
      run_transfer(32'h100, 16'd4, 1'b0, -1, cycles, fin);
      checks++;
      if (err_cnt !== 16'd1) begin errors++; $display("FAIL corrupt_cnt got %0d want 1", err_cnt); end
      checks++;
      if (first_err !== 32'h108) begin errors++; $display("FAIL corrupt_addr got %h want 00000108", first_err); end
      checks++;
      if (!fin || timeout !== 1'b0) begin errors++; $display("FAIL corrupt_to got fin=%b to=%b want 1 0", fin, timeout); end
      corrupt_en = 1'b0;
   endtask

   task automatic test_timeout();
      int cycles, ob, lat;
      bit fin;
      never_resp = 1'b1;
      ob = obs_q.size();
      run_transfer(32'h400, 16'd2, 1'b0, -1, cycles, fin);
      lat = cyc - last_rd_cyc;
      checks++;
      if (!fin || timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag got fin=%b to=%b want 1 1", fin, timeout); end
      checks++;
      if (lat < TO || lat > TO + 4) begin errors++; $display("FAIL timeout_latency got %0d want %0d..%0d", lat, TO, TO + 4); end
      checks++;
      if (obs_q.size() - ob !== 3) begin errors++; $display("FAIL timeout_traffic got %0d want 3", obs_q.size() - ob); end
      checks++;
      if (err_cnt !== 16'd0) begin errors++; $display("FAIL timeout_err got %0d want 0", err_cnt); end
      never_resp = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_zero_and_busy();
      int cycles, ob;
      bit fin;
      ob = obs_q.size();
      run_transfer(32'h800, 16'd0, 1'b0, -1, cycles, fin);
      checks++;
      if (!fin || cycles !== 1) begin errors++; $display("FAIL zero_latency got fin=%b cycles=%0d want 1 1", fin, cycles); end
      checks++;
      if (obs_q.size() !== ob) begin errors++; $display("FAIL zero_traffic got %0d want 0", obs_q.size() - ob); end
      ob = obs_q.size();
      build_expected(32'h200, 6, 1'b0);
      run_transfer(32'h200, 16'd6, 1'b0, 3, cycles, fin);
      checks++;
      if (obs_q.size() - ob !== exp_q.size()) begin
         errors++; $display("FAIL busy_count got %0d want %0d", obs_q.size() - ob, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[ob+i] !== exp_q[i]) begin
            errors++; $display("FAIL busy_txn%0d got %h want %h", i, obs_q[ob+i], exp_q[i]);
         end
      end
      checks++;
      if (err_cnt !== 16'd0) begin errors++; $display("FAIL busy_err got %0d want 0", err_cnt); end
   endtask

   task automatic test_wrap_and_reset();
      int cycles, ob;
      bit fin;
      ob = obs_q.size();
      build_expected(32'hFFFF_FFF8, 4, 1'b0);
      run_transfer(32'hFFFF_FFF8, 16'd4, 1'b0, -1, cycles, fin);
      checks++;
      if (obs_q.size() - ob !== 8) begin errors++; $display("FAIL wrap_count got %0d want 8", obs_q.size() - ob); end
      for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[ob+i] !== exp_q[i]) begin
            errors++; $display("FAIL wrap_txn%0d got %h want %h", i, obs_q[ob+i], exp_q[i]);
         end
      end
      checks++;
      if (err_cnt !== 16'd0) begin errors++; $display("FAIL wrap_err got %0d want 0", err_cnt); end
      @(negedge clk);
      base = 32'h1000; nwords = 16'd50; inv = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (req !== 1'b1 || we !== 1'b1) begin errors++; $display("FAIL midwrite_req got req=%b we=%b want 1 1", req, we); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL async_reset got req=%b busy=%b want 0 0", req, busy); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      ob = obs_q.size();
      repeat (20) @(negedge clk);
      checks++;
      if (obs_q.size() !== ob || busy !== 1'b0) begin
         errors++; $display("FAIL post_reset_traffic got %0d txns busy=%b want 0 0", obs_q.size() - ob, busy);
      end
      #1 spurious = 1'b1;
      @(negedge clk);
      #1 spurious = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({err_cnt, first_err, done, busy, timeout} !== '0) begin
         errors++; $display("FAIL stray_resp got err=%0d ferr=%h done=%b busy=%b want all 0", err_cnt, first_err, done, busy);
      end
   endtask

   task automatic test_random();
      int cycles, ob, ub, n, k;
      bit fin;
      logic [31:0] r, b, want_first;
      logic iv;
      logic [15:0] want_err;
      for (int it = 0; it < 6; it++) begin
         r = $urandom();
         b = r & 32'hFFFF_FFFC;
         n = $urandom_range(1, 8);
         iv = 1'($urandom_range(0, 1));
         stall_cfg = $urandom_range(0, 2);
         resp_lat = $urandom_range(0, 3);
         corrupt_en = 1'($urandom_range(0, 1));
         k = $urandom_range(0, n - 1);
         corrupt_addr = b + 32'(k) * 32'd4;
         want_err = corrupt_en ? 16'd1 : 16'd0;
         want_first = corrupt_en ? corrupt_addr : 32'd0;
         ob = obs_q.size(); ub = unstable;
         build_expected(b, n, iv);
         run_transfer(b, 16'(n), iv, -1, cycles, fin);
         checks++;
         if (!fin || obs_q.size() - ob !== exp_q.size()) begin
            errors++; $display("FAIL rand%0d_count got fin=%b %0d want %0d", it, fin, obs_q.size() - ob, exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[ob+i] !== exp_q[i]) begin
               errors++; $display("FAIL rand%0d_txn%0d got %h want %h", it, i, obs_q[ob+i], exp_q[i]);
            end
         end
         checks++;
         if (err_cnt !== want_err || first_err !== want_first || timeout !== 1'b0) begin
            errors++; $display("FAIL rand%0d_result got err=%0d ferr=%h to=%b want %0d %h 0",
                               it, err_cnt, first_err, timeout, want_err, want_first);
         end
         checks++;
         if (unstable !== ub) begin errors++; $display("FAIL rand%0d_stable got %0d want 0", it, unstable - ub); end
      end
      corrupt_en = 1'b0; stall_cfg = 0; resp_lat = 0;
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_stall();
      test_corrupt();
      test_timeout();
      test_zero_and_busy();
      test_wrap_and_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
